// File: rtl/fetch_unit.sv
// Instruction-fetch front end: req/ack fetch into a DEPTH-entry prefetch queue feeding decode.
// Optional build macro FETCH_PERF_EN adds fetch/flush event counters.
module fetch_unit #(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_jp_en,
    input  logic [XLEN-1:0] i_jp_addr,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_ack,
    input  logic [XLEN-1:0] i_imem_data,
    output logic            o_valid,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_pc,
    input  logic            i_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     o_fetch_cnt,
    output logic [31:0]     o_flush_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0]   CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]   PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] WORD_STEP = {{(XLEN-3){1'b0}}, 3'd4};
    localparam logic [XLEN-1:0] WORD_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & WORD_MASK;
    endfunction

    state_t          state_r, state_s;
    logic [XLEN-1:0] fetch_pc_r, fetch_pc_s;
    logic            req_r, req_s;
    logic [XLEN-1:0] addr_r, addr_s;
    logic [CW-1:0]   count_r;
    logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [XLEN-1:0] pc_mem_r   [DEPTH];
    logic [XLEN-1:0] inst_mem_r [DEPTH];

    logic            push_s;
    logic            pop_s;
    logic [CW-1:0]   count_push_s;
    logic [XLEN-1:0] target_s;
    logic [XLEN-1:0] next_pc_s;

    assign pop_s        = o_valid & i_ready & ~i_jp_en;
    assign count_push_s = count_r + CNT_ONE - (pop_s ? CNT_ONE : {CW{1'b0}});
    assign target_s     = align_word(i_jp_addr);
    assign next_pc_s    = fetch_pc_r + WORD_STEP;

    assign o_imem_req  = req_r;
    assign o_imem_addr = addr_r;
    assign o_valid     = (count_r != {CW{1'b0}});
    assign o_inst      = inst_mem_r[rd_ptr_r];
    assign o_pc        = pc_mem_r[rd_ptr_r];

    // Fetch FSM next-state: issue, back-to-back streaming, redirect and drain handling.
    always_comb begin
        state_s    = state_r;
        fetch_pc_s = fetch_pc_r;
        req_s      = req_r;
        addr_s     = addr_r;
        push_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_jp_en) begin
                    fetch_pc_s = target_s;
                end else if (count_r < DEPTH_C) begin
                    state_s = ST_WAIT;
                    req_s   = 1'b1;
                    addr_s  = fetch_pc_r;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (i_jp_en) begin
                    fetch_pc_s = target_s;
                    if (i_imem_ack) begin
                        state_s = ST_IDLE;
                        req_s   = 1'b0;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end else if (i_imem_ack) begin
                    push_s     = 1'b1;
                    fetch_pc_s = next_pc_s;
                    if (count_push_s < DEPTH_C) begin
                        addr_s = next_pc_s;
                    end else begin
                        state_s = ST_IDLE;
                        req_s   = 1'b0;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (i_jp_en) begin
                    fetch_pc_s = target_s;
                end else begin
                    fetch_pc_s = fetch_pc_r;
                end
                // The in-flight word belongs to the abandoned path: ack just frees the bus.
                if (i_imem_ack) begin
                    state_s = ST_IDLE;
                    req_s   = 1'b0;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                req_s   = 1'b0;
            end
        endcase
    end

    // Fetch FSM and bus-request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_PC;
            req_r      <= 1'b0;
            addr_r     <= RESET_PC;
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            req_r      <= req_s;
            addr_r     <= addr_s;
        end
    end

    // Prefetch queue: circular buffer, cleared wholesale on redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r  <= {CW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]   <= {XLEN{1'b0}};
                inst_mem_r[i] <= {XLEN{1'b0}};
            end
        end else if (i_jp_en) begin
            count_r  <= {CW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (push_s) begin
                pc_mem_r[wr_ptr_r]   <= fetch_pc_r;
                inst_mem_r[wr_ptr_r] <= i_imem_data;
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    // Event counters: accepted pushes and redirect cycles, free-running with wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_fetch_cnt <= 32'd0;
            o_flush_cnt <= 32'd0;
        end else begin
            o_fetch_cnt <= o_fetch_cnt + (push_s ? 32'd1 : 32'd0);
            o_flush_cnt <= o_flush_cnt + (i_jp_en ? 32'd1 : 32'd0);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: memory responder plus scoreboard of expected {pc, inst} entries.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_jp_en = 1'b0;
    logic [31:0] i_jp_addr = 32'h0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack = 1'b0;
    logic [31:0] i_imem_data = 32'h0;
    logic        o_valid;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        i_ready = 1'b0;
`ifdef FETCH_PERF_EN
    logic [31:0] o_fetch_cnt;
    logic [31:0] o_flush_cnt;
`endif

    fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_jp_en     (i_jp_en),
        .i_jp_addr   (i_jp_addr),
        .o_imem_req  (o_imem_req),
        .o_imem_addr (o_imem_addr),
        .i_imem_ack  (i_imem_ack),
        .i_imem_data (i_imem_data),
        .o_valid     (o_valid),
        .o_inst      (o_inst),
        .o_pc        (o_pc),
        .i_ready     (i_ready)
`ifdef FETCH_PERF_EN
        ,
        .o_fetch_cnt (o_fetch_cnt),
        .o_flush_cnt (o_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t      exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_addr;
    logic [31:0] held_addr;
    bit          prev_req;
    bit          prev_ack;
    bit          drain;
    int          wait_cnt;
    int          mem_lat;
    int          pops;
    logic [31:0] first_pop_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_addr  = 32'h0;
        held_addr = 32'h0;
        prev_req  = 1'b0;
        prev_ack  = 1'b0;
        drain     = 1'b0;
        wait_cnt  = 0;
        pops      = 0;
        first_pop_pc = 32'hXXXX_XXXX;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        i_jp_en = 1'b0;
        i_imem_ack = 1'b0;
        i_ready = 1'b0;
        #1;
        chk("rst_req", {31'd0, o_imem_req}, 32'd0);
        chk("rst_addr", o_imem_addr, 32'h0);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_inst", o_inst, 32'h0);
        chk("rst_pc", o_pc, 32'h0);
`ifdef FETCH_PERF_EN
        chk("rst_fetch_cnt", o_fetch_cnt, 32'd0);
        chk("rst_flush_cnt", o_flush_cnt, 32'd0);
`endif
        model_clear();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock cycle: drive inputs at the falling edge, act as memory and consumer, update the model.
    task automatic tick(input bit jp, input logic [31:0] jaddr, input bit rdy);
        bit     ack;
        entry_t e;
        @(negedge clk);
        i_jp_en   = jp;
        i_jp_addr = jaddr;
        i_ready   = rdy;
        ack = 1'b0;
        if (o_imem_req) begin
            if (prev_req && !prev_ack) begin
                chk("addr_hold", o_imem_addr, held_addr);
            end else begin
                chk("req_addr", o_imem_addr, exp_addr);
                held_addr = o_imem_addr;
                wait_cnt = 0;
            end
            if (wait_cnt >= mem_lat) ack = 1'b1;
            else wait_cnt++;
        end
        prev_req = o_imem_req;
        prev_ack = ack;
        i_imem_ack  = ack;
        i_imem_data = ack ? (held_addr ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
        if (o_valid && rdy && !jp) begin
            chk("pop_avail", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pop_pc", o_pc, e.pc);
                chk("pop_inst", o_inst, e.inst);
                if (pops == 0) first_pop_pc = o_pc;
                pops++;
            end
        end
        if (jp) exp_q.delete();
        if (ack) begin
            if (!(drain || jp)) begin
                exp_q.push_back('{held_addr, held_addr ^ 32'hA5A5_0000});
                exp_addr = held_addr + 32'd4;
            end
            drain = 1'b0;
        end else if (jp && o_imem_req) begin
            drain = 1'b1;
        end
        if (jp) exp_addr = jaddr & 32'hFFFF_FFFC;
    endtask

    initial begin
        mem_lat = 0;
        model_clear();

        // Streaming with zero-wait memory and an always-ready consumer.
        do_reset();
        mem_lat = 0;
        repeat (12) tick(1'b0, 32'h0, 1'b1);
        chk("stream_pops", pops, 32'd11);

        // Stalled consumer fills the queue, then drains in order.
        do_reset();
        repeat (8) tick(1'b0, 32'h0, 1'b0);
        chk("full_req_low", {31'd0, o_imem_req}, 32'd0);
        chk("full_pushes", exp_q.size(), 32'd4);
        chk("full_head_valid", {31'd0, o_valid}, 32'd1);
        chk("full_head_pc", o_pc, 32'h0);
        repeat (10) tick(1'b0, 32'h0, 1'b1);
        chk("resume_pops_ge4", {31'd0, pops >= 4}, 32'd1);

        // Redirect while a slow request is outstanding: response discarded.
        do_reset();
        mem_lat = 3;
        tick(1'b0, 32'h0, 1'b1);
        tick(1'b1, 32'h103, 1'b1);
        repeat (20) tick(1'b0, 32'h0, 1'b1);
        chk("drain_popped", {31'd0, pops != 0}, 32'd1);
        chk("drain_first_pc", first_pop_pc, 32'h100);

        // Redirect coinciding with ack and pop while two entries are queued.
        do_reset();
        mem_lat = 0;
        tick(1'b0, 32'h0, 1'b0);
        tick(1'b0, 32'h0, 1'b0);
        chk("pre_flush_valid", {31'd0, o_valid}, 32'd1);
        tick(1'b1, 32'h200, 1'b1);
        tick(1'b0, 32'h0, 1'b1);
        chk("flush_empty", {31'd0, o_valid}, 32'd0);
        repeat (6) tick(1'b0, 32'h0, 1'b1);
        chk("flush_first_pc", first_pop_pc, 32'h200);

        // Address wrap at the top of the address space.
        do_reset();
        tick(1'b1, 32'hFFFF_FFFC, 1'b1);
        repeat (6) tick(1'b0, 32'h0, 1'b1);
        chk("wrap_first_pc", first_pop_pc, 32'hFFFF_FFFC);
        chk("wrap_pops_ge2", {31'd0, pops >= 2}, 32'd1);

`ifdef FETCH_PERF_EN
        do_reset();
        repeat (10) tick(1'b0, 32'h0, 1'b1);
        tick(1'b1, 32'h40, 1'b1);
        tick(1'b1, 32'h40, 1'b1);
        @(negedge clk);
        i_jp_en = 1'b0;
        i_imem_ack = 1'b0;
        chk("perf_fetch_cnt", o_fetch_cnt, 32'd10);
        chk("perf_flush_cnt", o_flush_cnt, 32'd2);
        prev_req = o_imem_req;
        prev_ack = 1'b0;
        repeat (3) tick(1'b0, 32'h0, 1'b1);
        do_reset();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
